// File: rtl/uart_hex_ctrl.sv
// uart_hex_ctrl: two-digit ASCII hex receive path with uppercase echo.
// Receives bytes from a UART receiver, assembles two hex digits into one byte,
// publishes it, then echoes "<HI><LO>\r\n" through a busy-handshaked UART
// transmitter. Malformed input, inter-digit timeout and overrun during the
// echo are reported on err_flag.
module uart_hex_ctrl #(
  parameter int SYS_CLK_FRE = 50_000_000,
  parameter int TIMEOUT_MS  = 10
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_tx_busy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic [7:0] hex_value,
  output logic       hex_valid,
  output logic       err_flag
);

  // Inter-digit timeout in clocks.
  localparam logic [31:0] TIMEOUT_CYC = 32'(SYS_CLK_FRE / 1000 * TIMEOUT_MS);
  // Clocks after the en pulse to wait for busy before assuming the byte went out.
  localparam logic [2:0]  BUSY_WAIT   = 3'd4;
  // Last echo index (CR=2, LF=3).
  localparam logic [1:0]  LAST_IDX    = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    HAVE_HI,
    TX_LOAD,
    TX_START,
    TX_END
  } state_t;

  state_t      state_q, state_d;
  logic        done_q;
  logic [3:0]  hi_q, hi_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic [2:0]  wait_q, wait_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  hex_value_q, hex_value_d;
  logic        hex_valid_q, hex_valid_d;
  logic        err_q, err_d;

  logic        rx_evt;
  logic        rx_is_hex;
  logic        rx_is_ws;
  logic [3:0]  rx_nib;
  logic [7:0]  echo_byte;

  // Nibble to uppercase ASCII digit.
  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // One event per received byte, even when done is held for a whole bit time.
  assign rx_evt = uart_rx_done & ~done_q;

  // Classify the received byte: hex digit (either case), ignorable whitespace, or junk.
  always_comb begin
    rx_is_hex = 1'b0;
    rx_nib    = 4'h0;
    if (uart_rx_data >= 8'h30 && uart_rx_data <= 8'h39) begin
      rx_is_hex = 1'b1;
      rx_nib    = uart_rx_data[3:0];
    end else if ((uart_rx_data >= 8'h41 && uart_rx_data <= 8'h46) ||
                 (uart_rx_data >= 8'h61 && uart_rx_data <= 8'h66)) begin
      rx_is_hex = 1'b1;
      rx_nib    = uart_rx_data[3:0] + 4'd9;
    end
    rx_is_ws = (uart_rx_data == 8'h0D) || (uart_rx_data == 8'h0A) ||
               (uart_rx_data == 8'h20);
  end

  // Echo byte selected by index; digits come from the published value.
  always_comb begin
    echo_byte = 8'h0A;
    case (idx_q)
      2'd0:    echo_byte = to_ascii(hex_value_q[7:4]);
      2'd1:    echo_byte = to_ascii(hex_value_q[3:0]);
      2'd2:    echo_byte = 8'h0D;
      default: echo_byte = 8'h0A;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    wait_d      = wait_q;
    tx_data_d   = tx_data_q;
    hex_value_d = hex_value_q;
    tx_en_d     = 1'b0;
    hex_valid_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_evt) begin
          if (rx_is_hex) begin
            hi_d    = rx_nib;
            tmo_d   = 32'd0;
            state_d = HAVE_HI;
          end else if (!rx_is_ws) begin
            err_d = 1'b1;
          end
        end
      end

      HAVE_HI: begin
        // A byte arriving on the timeout clock still counts as the second digit.
        if (rx_evt) begin
          if (rx_is_hex) begin
            hex_value_d = {hi_q, rx_nib};
            hex_valid_d = 1'b1;
            idx_d       = 2'd0;
            state_d     = TX_LOAD;
          end else begin
            err_d   = 1'b1;
            hi_d    = 4'h0;
            state_d = IDLE;
          end
        end else if (tmo_q >= TIMEOUT_CYC - 32'd1) begin
          err_d   = 1'b1;
          hi_d    = 4'h0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      TX_LOAD: begin
        if (!uart_tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = echo_byte;
          wait_d    = 3'd0;
          state_d   = TX_START;
        end
      end

      TX_START: begin
        // A transmitter that never raises busy must not stall the echo.
        if (uart_tx_busy || wait_q == BUSY_WAIT) begin
          state_d = TX_END;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      TX_END: begin
        if (!uart_tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = TX_LOAD;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Bytes arriving during the echo are dropped; the echo itself carries on.
    if (rx_evt && (state_q == TX_LOAD || state_q == TX_START || state_q == TX_END))
      err_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      hi_q        <= 4'h0;
      idx_q       <= 2'd0;
      tmo_q       <= 32'd0;
      wait_q      <= 3'd0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      hex_value_q <= 8'h00;
      hex_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= uart_rx_done;
      hi_q        <= hi_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      wait_q      <= wait_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      hex_value_q <= hex_value_d;
      hex_valid_q <= hex_valid_d;
      err_q       <= err_d;
    end
  end

  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;
  assign hex_value    = hex_value_q;
  assign hex_valid    = hex_valid_q;
  assign err_flag     = err_q;

endmodule

// File: tb/tb_uart_hex_ctrl.sv
// Self-checking bench for uart_hex_ctrl: table of two-digit exchanges plus
// hand-written sequences for junk input, timeout, overrun, dead transmitter
// and mid-echo reset.
module tb_uart_hex_ctrl;
  localparam int CLK_FRE  = 1_000_000;
  localparam int TMO_MS   = 1;
  localparam int TMO_CYC  = 1000;
  localparam int BUSY_LEN = 12;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic       uart_tx_busy = 1'b0;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic [7:0] hex_value;
  logic       hex_valid;
  logic       err_flag;

  uart_hex_ctrl #(.SYS_CLK_FRE(CLK_FRE), .TIMEOUT_MS(TMO_MS)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
    .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data), .hex_value(hex_value),
    .hex_valid(hex_valid), .err_flag(err_flag)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // Transmitter model and output monitor (all sampled on the falling edge).
  bit         no_busy = 1'b0;
  int         bcnt = 0;
  int         tx_n = 0, hv_cnt = 0, er_cnt = 0;
  int         en_busy_viol = 0, hold_viol = 0, both_viol = 0;
  logic [7:0] tx_log [0:255];
  int         tx_t   [0:255];
  logic [7:0] last_data = 8'h00;

  always @(negedge sys_clk) begin
    if (uart_tx_en) begin
      if (uart_tx_busy) en_busy_viol++;
      if (tx_n < 256) begin
        tx_log[tx_n] = uart_tx_data;
        tx_t[tx_n]   = cyc;
      end
      tx_n++;
      last_data = uart_tx_data;
      if (!no_busy) begin
        uart_tx_busy = 1'b1;
        bcnt = BUSY_LEN;
      end
    end else begin
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) uart_tx_busy = 1'b0;
      end
      if (!sys_rst_n) last_data = 8'h00;
      else if (uart_tx_data != last_data) hold_viol++;
    end
    if (hex_valid) hv_cnt++;
    if (err_flag) er_cnt++;
    if (hex_valid && err_flag) both_viol++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap,
                           output int evt);
    @(negedge sys_clk);
    uart_rx_data = b;
    uart_rx_done = 1'b1;
    evt = cyc;
    repeat (hold) @(negedge sys_clk);
    uart_rx_done = 1'b0;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic wait_echo(input int base, input string nm);
    int k;
    k = 0;
    while ((tx_n - base < 4 || uart_tx_busy) && k < 5000) begin
      @(negedge sys_clk);
      k++;
    end
    if (k >= 5000) chk({nm, " echo wait timeout"}, k, 0);
    repeat (4) @(negedge sys_clk);
  endtask

  typedef struct {
    logic [7:0] c0;
    logic [7:0] c1;
    int         hold;
    logic [7:0] val;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  // Full two-digit exchange with expected value and echo.
  task automatic run_pair(input vec_t v, input string nm);
    int hb, eb, tb, ev0, ev1;
    hb = hv_cnt; eb = er_cnt; tb = tx_n;
    send_byte(v.c0, v.hold, 3, ev0);
    send_byte(v.c1, v.hold, 3, ev1);
    wait_echo(tb, nm);
    chk({nm, " hex_value"}, int'(hex_value), int'(v.val));
    chk({nm, " hex_valid pulses"}, hv_cnt - hb, 1);
    chk({nm, " err pulses"}, er_cnt - eb, 0);
    chk({nm, " tx count"}, tx_n - tb, 4);
    chk({nm, " echo0"}, int'(tx_log[tb]), int'(v.e0));
    chk({nm, " echo1"}, int'(tx_log[tb+1]), int'(v.e1));
    chk({nm, " echo2"}, int'(tx_log[tb+2]), 'h0D);
    chk({nm, " echo3"}, int'(tx_log[tb+3]), 'h0A);
    chk({nm, " en latency"}, tx_t[tb] - ev1, 2);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vt [4];

  initial begin
    int hb, eb, tb, ev, k, mx, mn, g;
    vt[0] = '{8'h41, 8'h35, 868, 8'hA5, 8'h41, 8'h35};  // "A5", long done
    vt[1] = '{8'h33, 8'h63, 6,   8'h3C, 8'h33, 8'h43};  // "3c" -> uppercase echo
    vt[2] = '{8'h39, 8'h61, 6,   8'h9A, 8'h39, 8'h41};  // "9a"
    vt[3] = '{8'h65, 8'h30, 6,   8'hE0, 8'h45, 8'h30};  // "e0"

    sys_rst_n = 1'b0;
    uart_rx_done = 1'b0;
    uart_rx_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("reset tx_en", int'(uart_tx_en), 0);
    chk("reset tx_data", int'(uart_tx_data), 0);
    chk("reset hex_value", int'(hex_value), 0);
    chk("reset hex_valid", int'(hex_valid), 0);
    chk("reset err_flag", int'(err_flag), 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 4; i++) run_pair(vt[i], $sformatf("vec%0d", i));

    // Junk and whitespace in IDLE.
    hb = hv_cnt; eb = er_cnt; tb = tx_n;
    send_byte(8'h47, 4, 5, ev);
    chk("G err pulses", er_cnt - eb, 1);
    chk("G no tx", tx_n - tb, 0);
    chk("G hex_value kept", int'(hex_value), 'hE0);
    send_byte(8'h0D, 4, 3, ev);
    send_byte(8'h0A, 4, 3, ev);
    send_byte(8'h20, 4, 5, ev);
    chk("whitespace no err", er_cnt - eb, 1);
    chk("junk no hex_valid", hv_cnt - hb, 0);

    // Inter-digit timeout, then recovery.
    eb = er_cnt; hb = hv_cnt; tb = tx_n;
    send_byte(8'h37, 5, 0, ev);
    while (cyc < ev + TMO_CYC - 5) @(negedge sys_clk);
    chk("timeout not early", er_cnt - eb, 0);
    k = 0;
    while (er_cnt == eb && k < 30) begin
      @(negedge sys_clk);
      k++;
    end
    chk("timeout err pulses", er_cnt - eb, 1);
    chk("timeout no hex_valid", hv_cnt - hb, 0);
    chk("timeout no tx", tx_n - tb, 0);
    run_pair('{8'h31, 8'h32, 6, 8'h12, 8'h31, 8'h32}, "after_timeout");

    // Overrun during echo with a transmitter that never raises busy.
    no_busy = 1'b1;
    hb = hv_cnt; eb = er_cnt; tb = tx_n;
    send_byte(8'h46, 3, 2, ev);
    send_byte(8'h46, 3, 0, ev);
    k = 0;
    while (tx_n == tb && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    send_byte(8'h58, 3, 2, ev);
    wait_echo(tb, "overrun");
    chk("overrun hex_value", int'(hex_value), 'hFF);
    chk("overrun hex_valid", hv_cnt - hb, 1);
    chk("overrun err pulses", er_cnt - eb, 1);
    chk("overrun tx count", tx_n - tb, 4);
    chk("overrun echo0", int'(tx_log[tb]), 'h46);
    chk("overrun echo1", int'(tx_log[tb+1]), 'h46);
    chk("overrun echo2", int'(tx_log[tb+2]), 'h0D);
    chk("overrun echo3", int'(tx_log[tb+3]), 'h0A);
    mx = 0; mn = 1000;
    for (int i = 0; i < 3; i++) begin
      g = tx_t[tb+i+1] - tx_t[tb+i];
      if (g > mx) mx = g;
      if (g < mn) mn = g;
    end
    chk("no-busy byte spacing in range", int'(mn >= 5 && mx <= 10), 1);
    no_busy = 1'b0;

    // Reset during the second echo byte.
    tb = tx_n;
    send_byte(8'h35, 3, 2, ev);
    send_byte(8'h41, 3, 0, ev);
    k = 0;
    while (tx_n - tb < 2 && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    chk("pre-reset second byte seen", tx_n - tb, 2);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst tx_en", int'(uart_tx_en), 0);
    chk("midrst tx_data", int'(uart_tx_data), 0);
    chk("midrst hex_value", int'(hex_value), 0);
    chk("midrst hex_valid", int'(hex_valid), 0);
    chk("midrst err_flag", int'(err_flag), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    k = 0;
    while (uart_tx_busy && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    repeat (2) @(negedge sys_clk);
    chk("no resumed echo", tx_n - tb, 2);
    run_pair('{8'h30, 8'h31, 6, 8'h01, 8'h30, 8'h31}, "after_reset");

    chk("en while busy", en_busy_viol, 0);
    chk("tx_data hold", hold_viol, 0);
    chk("err and hex_valid together", both_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
